// File: rtl/ddr3_pixel_writer_multiframe.sv
// Packs pixels into 256-bit words, buffers them in a show-ahead FIFO and writes
// them as Avalon-MM bursts into a ring of DDR3 frame buffers.
module ddr3_pixel_writer_multiframe #(
    parameter int          IN_WIDTH      = 16,
    parameter int          BURST_LEN     = 8,
    parameter int          NUM_PIXELS    = 2764800,
    parameter logic [31:0] START_ADDRESS = 32'h36000000,
    parameter logic [31:0] FRAME_STRIDE  = 32'h00600000,
    parameter int          NUM_FRAMES    = 3,
    parameter int          FIFO_DEPTH    = 64,
    parameter int          CONTINUOUS    = 1,
    localparam int         FW            = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int         LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                ddr3_clk,
    input  logic                ddr3_clk_reset_n,
    input  logic                enable,
    input  logic [IN_WIDTH-1:0] pixel,
    input  logic                pixel_valid,
    output logic                pixel_ready,
    output logic [26:0]         ddr3_write_address,
    output logic [255:0]        ddr3_write_data,
    output logic                ddr3_write,
    input  logic                ddr3_waitrequest,
    output logic [7:0]          ddr3_burstcount,
    output logic                frame_done,
    output logic [FW-1:0]       frame_index,
    output logic                busy,
    output logic [LW-1:0]       fifo_level
);

    localparam int PPW      = 256 / IN_WIDTH;
    localparam int WORDS    = (NUM_PIXELS + PPW - 1) / PPW;
    localparam int NBURST   = (WORDS + BURST_LEN - 1) / BURST_LEN;
    localparam int LAST_LEN = WORDS - (NBURST - 1) * BURST_LEN;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int PIW      = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_FIFO, WRITE, FRAME_END} state_t;

    state_t          state;
    logic            armed;
    logic            enable_d;
    logic [PIW-1:0]  pack_index;
    logic [31:0]     pix_count;
    logic [255:0]    pack_word;
    logic [255:0]    pack_next;
    logic [255:0]    push_word;
    logic            push_pending;
    logic [255:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [31:0]     burst_cnt;
    logic [7:0]      beat_index;
    logic [7:0]      blen;
    logic [FW-1:0]   cur_frame;
    logic [FW-1:0]   next_frame;
    logic            accept;
    logic            last_pixel;
    logic            pop;
    logic            start;

    function automatic logic [26:0] frame_base(input logic [FW-1:0] f);
        logic [31:0] byte_addr;
        byte_addr = START_ADDRESS + 32'(f) * FRAME_STRIDE;
        return 27'(byte_addr >> 5);
    endfunction

    // Two free words are required because a completed word lands in the FIFO one cycle late.
    assign pixel_ready     = armed && (32'(level) + 32'd2 <= 32'(FIFO_DEPTH));
    assign accept          = pixel_valid && pixel_ready;
    assign last_pixel      = (pix_count == 32'(NUM_PIXELS - 1));
    assign pop             = (state == WRITE) && !ddr3_waitrequest;
    assign blen            = (burst_cnt == 32'(NBURST - 1)) ? 8'(LAST_LEN) : 8'(BURST_LEN);
    assign start           = (CONTINUOUS != 0) ? enable : (enable && !enable_d);
    assign next_frame      = (cur_frame == FW'(NUM_FRAMES - 1)) ? '0 : cur_frame + FW'(1);
    assign ddr3_write_data = (level != '0) ? mem[rd_ptr] : '0;
    assign fifo_level      = level;

    always_comb begin
        pack_next = pack_word;
        pack_next[pack_index*IN_WIDTH +: IN_WIDTH] = pixel;
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            pack_index   <= '0;
            pix_count    <= '0;
            pack_word    <= '0;
            push_word    <= '0;
            push_pending <= 1'b0;
        end else begin
            push_pending <= 1'b0;
            if (accept) begin
                pix_count <= last_pixel ? 32'd0 : pix_count + 32'd1;
                if (pack_index == PIW'(PPW - 1) || last_pixel) begin
                    push_word    <= pack_next;
                    push_pending <= 1'b1;
                    pack_word    <= '0;
                    pack_index   <= '0;
                end else begin
                    pack_word  <= pack_next;
                    pack_index <= pack_index + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ddr3_clk) begin
        if (push_pending) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_pending) wr_ptr <= wr_ptr + 1'b1;
            if (pop)          rd_ptr <= rd_ptr + 1'b1;
            case ({push_pending, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            state              <= IDLE;
            armed              <= 1'b0;
            enable_d           <= 1'b0;
            ddr3_write         <= 1'b0;
            ddr3_write_address <= '0;
            ddr3_burstcount    <= 8'(BURST_LEN);
            burst_cnt          <= '0;
            beat_index         <= '0;
            cur_frame          <= '0;
            frame_index        <= '0;
            frame_done         <= 1'b0;
            busy               <= 1'b0;
        end else begin
            enable_d   <= enable;
            frame_done <= 1'b0;
            if (accept && last_pixel) armed <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ddr3_write_address <= frame_base(cur_frame);
                        burst_cnt          <= '0;
                        armed              <= 1'b1;
                        busy               <= 1'b1;
                        state              <= WAIT_FIFO;
                    end
                end
                WAIT_FIFO: begin
                    if (32'(level) >= 32'(blen)) begin
                        ddr3_burstcount <= blen;
                        beat_index      <= '0;
                        ddr3_write      <= 1'b1;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    if (!ddr3_waitrequest) begin
                        beat_index <= beat_index + 8'd1;
                        if (beat_index == ddr3_burstcount - 8'd1) begin
                            ddr3_write <= 1'b0;
                            if (burst_cnt == 32'(NBURST - 1)) begin
                                state <= FRAME_END;
                            end else begin
                                ddr3_write_address <= ddr3_write_address + 27'(BURST_LEN);
                                burst_cnt          <= burst_cnt + 32'd1;
                                state              <= WAIT_FIFO;
                            end
                        end
                    end
                end
                FRAME_END: begin
                    frame_done         <= 1'b1;
                    frame_index        <= cur_frame;
                    cur_frame          <= next_frame;
                    ddr3_write_address <= frame_base(next_frame);
                    burst_cnt          <= '0;
                    if (CONTINUOUS != 0 && enable) begin
                        armed <= 1'b1;
                        state <= WAIT_FIFO;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
